dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_arbiter_arb2_select.sv | 20 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the two-port data-memory
// arbiter.
//   state_t     - FSM encoding (IDLE / ACCESS / RESP)
//   PORT0/PORT1 - requester ids used for grant and response steering
//   req_ctl_t   - latched control of the granted request
//   misaligned  - word-alignment test on a byte address
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic id;
    logic we;
  } req_ctl_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_arb2_select.sv
// arb2_select: two-way winner select.
//   req0, req1 - pending requests
//   ptr        - id of the port favoured when both request
//   gnt        - winning port id (PORT0 when neither requests)
module arb2_select
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt
);

  always_comb begin
    gnt = PORT0;
    if (req0 && req1) gnt = ptr;
    else if (req1)    gnt = PORT1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters onto one single-cycle data memory.
// Each access takes IDLE (sample) -> ACCESS (strobe) -> RESP (ack), so a req
// sampled at edge N strobes in cycle N+1 and is acked in cycle N+2.
//   clk, reset           - clock, synchronous active-high reset
//   p*_req/we/addr/wdata - requester ports (req held until ack)
//   p*_ack/err           - one-cycle completion pulse, err on misaligned addr
//   rdata                - last successfully read word
//   mem_read/mem_write   - memory strobes, only in ACCESS
//   mem_addr/mem_wdata   - latched address / write data
//   mem_rdata            - combinational read data from memory
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; otherwise
// p0 has fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_nxt;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              gnt, ptr, bad;
  logic              any_req, take;

  assign any_req = p0_req | p1_req;
  assign take    = (state == IDLE) && any_req;
  assign bad     = misaligned(addr_q[1:0]);

`ifdef DMEM_ARB_RR_EN
  // Pointer moves only on contested grants, so an uncontested grant to the
  // previous loser does not steal its turn on the next conflict.
  logic ptr_q;
  always_ff @(posedge clk) begin
    if (reset)                  ptr_q <= PORT0;
    else if (take && p0_req && p1_req) ptr_q <= ~gnt;
  end
  assign ptr = ptr_q;
`else
  assign ptr = PORT0;
`endif

  arb2_select u_sel (
    .req0 (p0_req),
    .req1 (p1_req),
    .ptr  (ptr),
    .gnt  (gnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request latch and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (take) begin
        ctl_q.id <= gnt;
        ctl_q.we <= (gnt == PORT1) ? p1_we    : p0_we;
        addr_q   <= (gnt == PORT1) ? p1_addr  : p0_addr;
        wdata_q  <= (gnt == PORT1) ? p1_wdata : p0_wdata;
      end
      if (state == ACCESS && !ctl_q.we && !bad) rdata <= mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // outputs
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    case (state)
      ACCESS: begin
        mem_read  = !ctl_q.we && !bad;
        mem_write =  ctl_q.we && !bad;
      end
      RESP: begin
        p0_ack = (ctl_q.id == PORT0);
        p1_ack = (ctl_q.id == PORT1);
        p0_err = (ctl_q.id == PORT0) && bad;
        p1_err = (ctl_q.id == PORT1) && bad;
      end
      default: ;
    endcase
  end

endmodule
